// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared word width and entry type for filter pipeline stages
package filter_pkg;

  localparam int DATA_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              parity;
  } filter_entry_t;

  localparam int ENTRY_W = $bits(filter_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with occupancy count
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_pop  = i_rd_en && !o_empty;
  assign w_push = i_wr_en && (!o_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left unreset; stale entries are hidden by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/filter_sink.sv
// rtl/filter_sink.sv - terminal filter stage: buffers words, counts drops on overflow
// Upstream cannot be stalled, so a word arriving at a full FIFO with no pop is lost.
module filter_sink
  import filter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       io_x_data,
  input  logic                    io_x_valid,
  input  logic                    io_x_parity,
  input  logic                    io_clear,
  input  logic                    io_y_ready,
  output logic [DATA_W-1:0]       io_y_data,
  output logic                    io_y_parity,
  output logic                    io_y_valid,
  output logic [$clog2(DEPTH):0]  io_count,
  output logic                    io_overflow,
  output logic [CNT_W-1:0]        io_drops
);

  localparam logic [CNT_W-1:0] DROP_MAX = '1;

  filter_entry_t    w_wr_entry;
  filter_entry_t    w_rd_entry;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_drop;
  logic             r_overflow;
  logic [CNT_W-1:0] r_drops;

  assign w_wr_entry = '{data: io_x_data, parity: io_x_parity};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (io_x_valid),
    .i_wr_data (w_wr_entry),
    .i_rd_en   (io_y_ready),
    .o_rd_data (w_rd_entry),
    .o_count   (io_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign io_y_valid  = !w_empty;
  assign io_y_data   = w_rd_entry.data;
  assign io_y_parity = w_rd_entry.parity;

  assign w_pop  = io_y_valid && io_y_ready;
  assign w_drop = io_x_valid && w_full && !w_pop;

  // Clear takes priority over a coincident drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_drops    <= '0;
    end else if (io_clear) begin
      r_overflow <= 1'b0;
      r_drops    <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drops != DROP_MAX) r_drops <= r_drops + 1'b1;
    end
  end

  assign io_overflow = r_overflow;
  assign io_drops    = r_drops;

endmodule

// File: tb/tb_filter_sink.sv
// tb/tb_filter_sink.sv - randomized and directed self-checking bench for filter_sink
module tb_filter_sink;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] io_x_data = '0;
  logic        io_x_valid = 1'b0;
  logic        io_x_parity = 1'b0;
  logic        io_clear = 1'b0;
  logic        io_y_ready = 1'b0;
  logic [15:0] io_y_data;
  logic        io_y_parity;
  logic        io_y_valid;
  logic [2:0]  io_count;
  logic        io_overflow;
  logic [1:0]  io_drops;

  int checks = 0;
  int errors = 0;

  logic [16:0] m_q[$];
  int          m_drops = 0;
  logic        m_ovf = 1'b0;

  filter_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .io_x_data   (io_x_data),
    .io_x_valid  (io_x_valid),
    .io_x_parity (io_x_parity),
    .io_clear    (io_clear),
    .io_y_ready  (io_y_ready),
    .io_y_data   (io_y_data),
    .io_y_parity (io_y_parity),
    .io_y_valid  (io_y_valid),
    .io_count    (io_count),
    .io_overflow (io_overflow),
    .io_drops    (io_drops)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of {data,parity}; drops only when full and nothing leaves.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_drops = 0;
      m_ovf   = 1'b0;
    end else begin
      bit popped;
      bit was_full;
      bit dropped;
      was_full = (m_q.size() == DEPTH);
      popped   = (m_q.size() != 0) && io_y_ready;
      dropped  = io_x_valid && was_full && !popped;
      if (popped) void'(m_q.pop_front());
      if (io_x_valid && !dropped) m_q.push_back({io_x_data, io_x_parity});
      if (io_clear) begin
        m_drops = 0;
        m_ovf   = 1'b0;
      end else if (dropped) begin
        m_ovf = 1'b1;
        if (m_drops < DROP_MAX) m_drops++;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_valid", io_y_valid, m_q.size() != 0);
    check("cyc_count", io_count, m_q.size());
    check("cyc_overflow", io_overflow, m_ovf);
    check("cyc_drops", io_drops, m_drops);
    if (m_q.size() != 0) begin
      check("cyc_data", io_y_data, m_q[0][16:1]);
      check("cyc_parity", io_y_parity, m_q[0][0]);
    end
  end

  task automatic cyc(input logic v, input logic [15:0] d, input logic p,
                     input logic rdy, input logic clr);
    io_x_valid  = v;
    io_x_data   = d;
    io_x_parity = p;
    io_y_ready  = rdy;
    io_clear    = clr;
    @(negedge clk);
  endtask

  initial begin
    #12;
    check("rst_valid", io_y_valid, 0);
    check("rst_count", io_count, 0);
    check("rst_overflow", io_overflow, 0);
    check("rst_drops", io_drops, 0);
    @(negedge clk);
    reset = 1'b0;

    cyc(1, 16'h1234, 1, 0, 0);
    check("first_valid", io_y_valid, 1);
    check("first_data", io_y_data, 16'h1234);
    check("first_parity", io_y_parity, 1);
    check("first_count", io_count, 1);
    cyc(0, 0, 0, 1, 0);
    check("first_drained", io_y_valid, 0);

    for (int i = 1; i <= 5; i++) cyc(1, 16'(16'hA000 + i), i[0], 0, 0);
    check("fill_count", io_count, 4);
    check("fill_overflow", io_overflow, 1);
    check("fill_drops", io_drops, 1);
    for (int i = 1; i <= 4; i++) begin
      check("fill_order", io_y_data, 16'(16'hA000 + i));
      cyc(0, 0, 0, 1, 0);
    end
    check("fill_empty", io_y_valid, 0);

    for (int i = 1; i <= 4; i++) cyc(1, 16'(16'hC000 + i), 0, 0, 0);
    cyc(1, 16'hBEEF, 1, 1, 0);
    check("full_pp_count", io_count, 4);
    check("full_pp_drops", io_drops, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 0);
    check("full_pp_beef", io_y_data, 16'hBEEF);
    check("full_pp_beef_count", io_count, 1);
    cyc(0, 0, 0, 1, 0);

    cyc(0, 0, 0, 0, 1);
    check("clr_drops", io_drops, 0);
    check("clr_overflow", io_overflow, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 16'(16'hE000 + i), 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 16'hDEAD, 0, 0, 0);
    check("sat_drops", io_drops, 3);
    check("sat_overflow", io_overflow, 1);
    cyc(1, 16'hF00F, 0, 0, 1);
    check("clr_win_drops", io_drops, 0);
    check("clr_win_overflow", io_overflow, 0);
    check("clr_win_count", io_count, 4);
    check("clr_win_head", io_y_data, 16'hE001);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);

    cyc(1, 16'hD000, 0, 1, 0);
    for (int i = 1; i <= 20; i++) begin
      check("stream_data", io_y_data, 16'(16'hD000 + i - 1));
      check("stream_count", io_count, 1);
      cyc(1, 16'(16'hD000 + i), i[0], 1, 0);
    end
    check("stream_last", io_y_data, 16'hD014);
    cyc(0, 0, 0, 1, 0);

    for (int i = 1; i <= 3; i++) cyc(1, 16'(16'h7000 + i), 0, 0, 0);
    check("pre_rst_count", io_count, 3);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", io_y_valid, 0);
    check("async_rst_count", io_count, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 16'h0042, 0, 0, 0);
    check("post_rst_data", io_y_data, 16'h0042);
    check("post_rst_count", io_count, 1);

    for (int i = 0; i < 400; i++) begin
      logic rdy;
      rdy = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      cyc($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom),
          rdy, $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
